// File: rtl/tl_pkg.sv
// Shared transaction-layer types.
//   tl_cpl_req_t : non-posted read request descriptor queued for completion
//   tl_cpl_hdr_t : CplD header fields as presented on the header handshake
//   TL_DW_BYTES  : bytes per DW
package tl_pkg;

    localparam int TL_DW_BYTES = 4;

    typedef struct packed {
        logic [7:0]  tag;
        logic [15:0] req_id;
        logic [31:0] addr;
        logic [9:0]  len;      // 0 encodes 1024 DW
        logic [2:0]  attr;
        logic [2:0]  tc;
    } tl_cpl_req_t;

    typedef struct packed {
        logic [7:0]  tag;
        logic [15:0] req_id;
        logic [15:0] cid;
        logic [9:0]  len;
        logic [11:0] byte_cnt; // 0 encodes 4096
        logic [6:0]  lower_addr;
        logic [2:0]  attr;
        logic [2:0]  tc;
    } tl_cpl_hdr_t;

endpackage

// File: rtl/tl_sync_fifo.sv
// Synchronous FIFO with async active-low reset; head entry is shown
// combinationally on rdata_o while not empty.
//   push_i/wdata_i : write (ignored when full)
//   pop_i/rdata_o  : read (ignored when empty)
//   full_o/empty_o : status
module tl_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4   // power of 2, >= 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int AW = $clog2(DEPTH);

    logic [DEPTH-1:0][WIDTH-1:0] mem_q;
    logic [AW-1:0]               wr_ptr_q, rd_ptr_q;
    logic [AW:0]                 cnt_q;
    logic                        do_push, do_pop;

    assign full_o  = (cnt_q == (AW+1)'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign rdata_o = mem_q[rd_ptr_q];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= wdata_i;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (do_pop)
                rd_ptr_q <= rd_ptr_q + 1'b1;
            cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

endmodule

// File: rtl/tl_cpl_gen.sv
// Completion generator: queues read requests, splits each into CplD chunks
// at MPS/RCB boundaries, fetches payload from local DW memory and streams it.
//   req_*        : request descriptor handshake (into a REQ_DEPTH FIFO)
//   mem_*        : local memory read port, data returns 1 cycle after strobe
//   cpl_hdr_*    : completion header handshake, fields from hdr_q
//   cpl_data_*   : completion payload stream, last flags final DW of chunk
module tl_cpl_gen import tl_pkg::*; #(
    parameter int MPS_DW    = 32,
    parameter int RCB_DW    = 16,
    parameter int REQ_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] completer_id_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [7:0]  req_tag_i,
    input  logic [15:0] req_id_i,
    input  logic [31:0] req_addr_i,
    input  logic [9:0]  req_len_i,
    input  logic [2:0]  req_attr_i,
    input  logic [2:0]  req_tc_i,
    output logic        mem_rd_en_o,
    output logic [31:0] mem_rd_addr_o,
    input  logic [31:0] mem_rdata_i,
    output logic        cpl_hdr_valid_o,
    input  logic        cpl_hdr_ready_i,
    output logic [7:0]  cpl_tag_o,
    output logic [15:0] cpl_req_id_o,
    output logic [15:0] cpl_cid_o,
    output logic [9:0]  cpl_len_o,
    output logic [11:0] cpl_byte_cnt_o,
    output logic [6:0]  cpl_lower_addr_o,
    output logic [2:0]  cpl_attr_o,
    output logic [2:0]  cpl_tc_o,
    output logic        cpl_data_valid_o,
    input  logic        cpl_data_ready_i,
    output logic [31:0] cpl_data_o,
    output logic        cpl_data_last_o
);
    typedef enum logic [1:0] {S_IDLE, S_HDR, S_DATA} state_e;

    state_e      state_q, state_d;
    tl_cpl_req_t req_in, req_head;
    tl_cpl_hdr_t hdr_q, hdr_d;
    logic        fifo_full, fifo_empty, fifo_pop;

    logic [10:0]      rem_q;          // DWs not yet covered by a header
    logic [31:0]      cur_addr_q;     // start of the next chunk
    logic [31:0]      rd_addr_q;
    logic [9:0]       iss_cnt_q;      // reads issued in this chunk
    logic [9:0]       out_cnt_q;      // DWs delivered in this chunk
    logic             pend_q;         // read issued last cycle, data on mem_rdata_i
    logic [1:0]       occ_q;
    logic             head_q;
    logic [1:0][31:0] buf_q;

    logic        form_hdr, hdr_hs, dat_valid, dat_hs, last_hs, rd_en;
    logic        buf_push, buf_pop;
    logic [10:0] form_rem;
    logic [31:0] form_addr;
    logic [9:0]  room, chunk;

    assign req_in = '{tag: req_tag_i, req_id: req_id_i, addr: req_addr_i,
                      len: req_len_i, attr: req_attr_i, tc: req_tc_i};
    assign req_ready_o = !fifo_full;

    tl_sync_fifo #(.WIDTH($bits(tl_cpl_req_t)), .DEPTH(REQ_DEPTH)) u_req_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (req_valid_i),
        .wdata_i (req_in),
        .pop_i   (fifo_pop),
        .rdata_o (req_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // Room up to the next MPS-sized window measured from the RCB alignment;
    // clipping to it makes every non-final chunk end on an RCB boundary.
    assign room  = 10'(MPS_DW) - (form_addr[11:2] & 10'(RCB_DW - 1));
    assign chunk = (form_rem < {1'b0, room}) ? form_rem[9:0] : room;

    assign hdr_hs    = (state_q == S_HDR) && cpl_hdr_ready_i;
    // Buffer head, or the DW returning from memory this cycle when empty.
    assign dat_valid = (state_q == S_DATA) && ((occ_q != 2'd0) || pend_q);
    assign dat_hs    = dat_valid && cpl_data_ready_i;
    assign last_hs   = dat_hs && (out_cnt_q == hdr_q.len - 10'd1);
    assign buf_pop   = dat_hs && (occ_q != 2'd0);
    assign buf_push  = pend_q && !(dat_hs && (occ_q == 2'd0));
    assign rd_en     = (state_q == S_DATA)
                     && (({1'b0, occ_q} + {2'b0, pend_q}) < 3'd2)
                     && (iss_cnt_q < hdr_q.len);

    always_comb begin
        state_d   = state_q;
        fifo_pop  = 1'b0;
        form_hdr  = 1'b0;
        form_rem  = rem_q;
        form_addr = cur_addr_q;
        case (state_q)
            S_IDLE: if (!fifo_empty) begin
                fifo_pop  = 1'b1;
                form_hdr  = 1'b1;
                form_rem  = (req_head.len == 10'd0) ? 11'd1024 : {1'b0, req_head.len};
                form_addr = req_head.addr & 32'hFFFF_FFFC;
                state_d   = S_HDR;
            end
            S_HDR: if (cpl_hdr_ready_i) state_d = S_DATA;
            S_DATA: if (last_hs) begin
                if (rem_q == 11'd0) begin
                    state_d = S_IDLE;
                end else begin
                    form_hdr = 1'b1;
                    state_d  = S_HDR;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        hdr_d = hdr_q;
        if (state_q == S_IDLE) begin
            hdr_d.tag    = req_head.tag;
            hdr_d.req_id = req_head.req_id;
            hdr_d.attr   = req_head.attr;
            hdr_d.tc     = req_head.tc;
        end
        hdr_d.cid        = completer_id_i;
        hdr_d.len        = chunk;
        hdr_d.byte_cnt   = {form_rem[9:0], 2'b00};
        hdr_d.lower_addr = {form_addr[6:2], 2'b00};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            hdr_q      <= '0;
            rem_q      <= '0;
            cur_addr_q <= '0;
            rd_addr_q  <= '0;
            iss_cnt_q  <= '0;
            out_cnt_q  <= '0;
            pend_q     <= 1'b0;
            occ_q      <= '0;
            head_q     <= 1'b0;
            buf_q      <= '0;
        end else begin
            state_q <= state_d;
            if (form_hdr) begin
                hdr_q      <= hdr_d;
                rem_q      <= form_rem;
                cur_addr_q <= form_addr;
            end
            if (hdr_hs) begin
                cur_addr_q <= cur_addr_q + {20'b0, hdr_q.len, 2'b00};
                rem_q      <= rem_q - {1'b0, hdr_q.len};
                rd_addr_q  <= cur_addr_q;
                iss_cnt_q  <= '0;
                out_cnt_q  <= '0;
            end
            if (rd_en) begin
                rd_addr_q <= rd_addr_q + 32'(TL_DW_BYTES);
                iss_cnt_q <= iss_cnt_q + 10'd1;
            end
            if (dat_hs)
                out_cnt_q <= out_cnt_q + 10'd1;
            pend_q <= rd_en;
            if (buf_push)
                buf_q[head_q ^ occ_q[0]] <= mem_rdata_i;
            occ_q  <= occ_q + {1'b0, buf_push} - {1'b0, buf_pop};
            head_q <= head_q ^ buf_pop;
        end
    end

    assign mem_rd_en_o      = rd_en;
    assign mem_rd_addr_o    = rd_addr_q;
    assign cpl_hdr_valid_o  = (state_q == S_HDR);
    assign cpl_tag_o        = hdr_q.tag;
    assign cpl_req_id_o     = hdr_q.req_id;
    assign cpl_cid_o        = hdr_q.cid;
    assign cpl_len_o        = hdr_q.len;
    assign cpl_byte_cnt_o   = hdr_q.byte_cnt;
    assign cpl_lower_addr_o = hdr_q.lower_addr;
    assign cpl_attr_o       = hdr_q.attr;
    assign cpl_tc_o         = hdr_q.tc;
    assign cpl_data_valid_o = dat_valid;
    assign cpl_data_o       = !dat_valid ? 32'd0 : ((occ_q != 2'd0) ? buf_q[head_q] : mem_rdata_i);
    assign cpl_data_last_o  = dat_valid && (out_cnt_q == hdr_q.len - 10'd1);

endmodule
